// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared types and constants for the VGA text buffer (scroll via VGA_TEXT_SCROLL_EN)
package vga_text_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SC_RD,
    ST_SC_WR,
    ST_SC_FILL
  } fill_state_e;

  localparam int CTRL_CLEAR  = 0;
  localparam int CTRL_SCROLL = 1;

  localparam logic [7:0] DEFAULT_BLANK = 8'h20;

endpackage

// File: rtl/vga_text_fill_fsm.sv
// rtl/vga_text_fill_fsm.sv - clear/scroll fill engine; scroll states built only with VGA_TEXT_SCROLL_EN
module vga_text_fill_fsm
  import vga_text_pkg::*;
#(
  parameter  int CHARS = 36,
  parameter  int COLS  = 12,
  localparam int IW    = $clog2(CHARS)
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          start_clear,
  input  logic          start_scroll,
  output logic          busy,
  output logic          wr_en,
  output logic [IW-1:0] wr_idx,
  output logic          wr_sel_latched,
  output logic          rd_en,
  output logic [IW-1:0] rd_idx
);

  localparam logic [IW-1:0] LAST    = IW'(CHARS - 1);
  localparam logic [IW-1:0] SC_LAST = IW'(CHARS - COLS - 1);
  localparam logic [IW-1:0] SC_BASE = IW'(CHARS - COLS);
  localparam logic [IW-1:0] ROW     = IW'(COLS);

  fill_state_e   state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;

  // Reset lands in CLR so the buffer blanks itself without a combinational clear.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_CLR;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    wr_en          = 1'b0;
    wr_sel_latched = 1'b0;
    rd_en          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_clear) begin
          state_nxt = ST_CLR;
          idx_nxt   = '0;
        end
`ifdef VGA_TEXT_SCROLL_EN
        else if (start_scroll) begin
          state_nxt = (CHARS == COLS) ? ST_SC_FILL : ST_SC_RD;
          idx_nxt   = '0;
        end
`endif
      end
      ST_CLR: begin
        wr_en   = 1'b1;
        idx_nxt = idx + IW'(1);
        if (idx == LAST) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
        end
      end
`ifdef VGA_TEXT_SCROLL_EN
      ST_SC_RD: begin
        rd_en     = 1'b1;
        state_nxt = ST_SC_WR;
      end
      ST_SC_WR: begin
        wr_en          = 1'b1;
        wr_sel_latched = 1'b1;
        if (idx == SC_LAST) begin
          state_nxt = ST_SC_FILL;
          idx_nxt   = SC_BASE;
        end else begin
          state_nxt = ST_SC_RD;
          idx_nxt   = idx + IW'(1);
        end
      end
      ST_SC_FILL: begin
        wr_en   = 1'b1;
        idx_nxt = idx + IW'(1);
        if (idx == LAST) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
        end
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

`ifndef VGA_TEXT_SCROLL_EN
  logic unused_scroll;
  assign unused_scroll = start_scroll;
`endif

  assign busy   = (state != ST_IDLE);
  assign wr_idx = idx;
  assign rd_idx = idx + ROW;

endmodule

// File: rtl/vga_text_buffer.sv
// rtl/vga_text_buffer.sv - memory-mapped VGA character buffer with fill engine; scroll via VGA_TEXT_SCROLL_EN
module vga_text_buffer
  import vga_text_pkg::*;
#(
  parameter  logic [63:0]       ADDR_BASE = 64'h0B00_0000,
  parameter  int                CHARS     = 36,
  parameter  int                COLS      = 12,
  parameter  int                CHAR_W    = 8,
  parameter  logic [CHAR_W-1:0] BLANK     = DEFAULT_BLANK,
  parameter  logic [63:0]       CTRL_OFF  = 64'h100,
  localparam int                IW        = $clog2(CHARS)
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [63:0]       cpu_addr,
  input  logic [63:0]       cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [63:0]       cpu_rdata,
  output logic              cpu_rvalid,
  input  logic [IW-1:0]     scan_addr,
  output logic [CHAR_W-1:0] scan_char,
  output logic              busy
);

  logic [CHAR_W-1:0] mem [CHARS];
  logic [CHAR_W-1:0] latch_q;

  logic [63:0]       off;
  logic [IW-1:0]     cpu_idx;
  logic              is_char, is_ctrl;
  logic              cpu_char_we, ctrl_we;
  logic              start_clear, start_scroll;

  logic              fsm_wr_en, fsm_sel_latched, fsm_rd_en;
  logic [IW-1:0]     fsm_wr_idx, fsm_rd_idx;

  logic              mem_we;
  logic [IW-1:0]     mem_widx;
  logic [CHAR_W-1:0] mem_wdata;

  assign off     = cpu_addr - ADDR_BASE;
  assign cpu_idx = off[IW-1:0];
  assign is_char = (off < 64'(CHARS));
  assign is_ctrl = (off == CTRL_OFF);

  // CPU writes and commands are simply dropped while the engine owns the array.
  assign cpu_char_we  = cpu_we & ~busy & is_char;
  assign ctrl_we      = cpu_we & ~busy & is_ctrl;
  assign start_clear  = ctrl_we & cpu_wdata[CTRL_CLEAR];
  assign start_scroll = ctrl_we & cpu_wdata[CTRL_SCROLL];

  vga_text_fill_fsm #(
    .CHARS (CHARS),
    .COLS  (COLS)
  ) u_fill_fsm (
    .clk            (clk),
    .aresetn        (aresetn),
    .start_clear    (start_clear),
    .start_scroll   (start_scroll),
    .busy           (busy),
    .wr_en          (fsm_wr_en),
    .wr_idx         (fsm_wr_idx),
    .wr_sel_latched (fsm_sel_latched),
    .rd_en          (fsm_rd_en),
    .rd_idx         (fsm_rd_idx)
  );

  assign mem_we    = fsm_wr_en | cpu_char_we;
  assign mem_widx  = fsm_wr_en ? fsm_wr_idx : cpu_idx;
  assign mem_wdata = fsm_wr_en ? (fsm_sel_latched ? latch_q : BLANK)
                               : cpu_wdata[CHAR_W-1:0];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
    if (fsm_rd_en) begin
      latch_q <= mem[fsm_rd_idx];
    end
  end

  // Read ports sample the array before this cycle's write lands, so same-cycle
  // read/write of one entry returns the old character.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      scan_char  <= '0;
    end else begin
      cpu_rvalid <= cpu_re;
      scan_char  <= mem[scan_addr];
      if (cpu_re && is_char) begin
        cpu_rdata <= {{(64-CHAR_W){1'b0}}, mem[cpu_idx]};
      end else if (cpu_re && is_ctrl) begin
        cpu_rdata <= {63'b0, busy};
      end else begin
        cpu_rdata <= '0;
      end
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^cpu_wdata[63:CHAR_W];

endmodule

// File: tb/tb_vga_text_buffer.sv
// tb/tb_vga_text_buffer.sv - randomized self-checking bench for vga_text_buffer (honours VGA_TEXT_SCROLL_EN)
module tb_vga_text_buffer;

  localparam logic [63:0] BASE  = 64'h0B00_0000;
  localparam int          CHARS = 36;
  localparam int          COLS  = 12;
  localparam logic [63:0] CTRL  = 64'h100;
  localparam logic [7:0]  BLANK = 8'h20;

  logic        clk = 1'b0;
  logic        aresetn = 1'b1;
  logic [63:0] cpu_addr = '0;
  logic [63:0] cpu_wdata = '0;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [63:0] cpu_rdata;
  logic        cpu_rvalid;
  logic [5:0]  scan_addr = '0;
  logic [7:0]  scan_char;
  logic        busy;

  logic [7:0]  model [CHARS];
  int          checks = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  vga_text_buffer dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .scan_addr  (scan_addr),
    .scan_char  (scan_char),
    .busy       (busy)
  );

  task automatic wr(input logic [63:0] off, input logic [63:0] data);
    @(negedge clk);
    cpu_addr = BASE + off; cpu_wdata = data; cpu_we = 1'b1;
    @(posedge clk); #1;
    cpu_we = 1'b0;
  endtask

  task automatic rd(input logic [63:0] off, output logic [63:0] d, output logic v);
    @(negedge clk);
    cpu_addr = BASE + off; cpu_re = 1'b1;
    @(posedge clk); #1;
    cpu_re = 1'b0;
    d = cpu_rdata; v = cpu_rvalid;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic fill_pattern(input bit rand_data);
    for (int i = 0; i < CHARS; i++) begin
      model[i] = rand_data ? 8'($urandom) : 8'(8'h41 + i);
      wr(64'(i), {$urandom, 24'($urandom), model[i]});
    end
  endtask

  task automatic test_reset;
    int n;
    #2 aresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cpu_rdata !== 64'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", cpu_rdata); end
    checks++; if (cpu_rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got %b expected 0", cpu_rvalid); end
    checks++; if (scan_char !== 8'h0) begin fails++; $display("FAIL reset_scan: got %h expected 0", scan_char); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b expected 1", busy); end
    @(negedge clk) aresetn = 1'b1;
    count_busy(n);
    checks++; if (n !== 36) begin fails++; $display("FAIL reset_clear_len: got %0d expected 36", n); end
    for (int i = 0; i < CHARS; i++) model[i] = BLANK;
    for (int i = 0; i < CHARS; i++) begin
      logic [63:0] d; logic v;
      rd(64'(i), d, v);
      checks++; if (d !== 64'(BLANK) || v !== 1'b1) begin fails++; $display("FAIL reset_blank[%0d]: got %h/%b expected %h/1", i, d, v, BLANK); end
    end
  endtask

  task automatic test_char_rw;
    logic [63:0] d; logic v;
    wr(64'd5, 64'h48); model[5] = 8'h48;
    rd(64'd5, d, v);
    checks++; if (d !== 64'h48 || v !== 1'b1) begin fails++; $display("FAIL char_rd5: got %h/%b expected 48/1", d, v); end
    @(negedge clk) scan_addr = 6'd5;
    @(posedge clk); #1;
    checks++; if (scan_char !== 8'h48) begin fails++; $display("FAIL scan5: got %h expected 48", scan_char); end
    repeat (24) begin
      int i; logic [63:0] w;
      i = $urandom_range(0, CHARS - 1);
      w = {$urandom, $urandom};
      wr(64'(i), w); model[i] = w[7:0];
      rd(64'(i), d, v);
      checks++; if (d !== {56'h0, model[i]} || v !== 1'b1) begin fails++; $display("FAIL char_rand[%0d]: got %h expected %h", i, d, {56'h0, model[i]}); end
    end
    for (int i = 0; i < CHARS; i++) begin
      @(negedge clk) scan_addr = 6'(i);
      @(posedge clk); #1;
      checks++; if (scan_char !== model[i]) begin fails++; $display("FAIL scan[%0d]: got %h expected %h", i, scan_char, model[i]); end
    end
  endtask

  task automatic test_same_cycle;
    int i; logic [7:0] nv; logic [7:0] old; logic [63:0] d; logic v;
    i = $urandom_range(0, CHARS - 1);
    old = model[i];
    nv = ~old;
    @(negedge clk);
    cpu_addr = BASE + 64'(i); cpu_wdata = {56'h0, nv}; cpu_we = 1'b1; cpu_re = 1'b1;
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_re = 1'b0;
    checks++; if (cpu_rdata !== {56'h0, old}) begin fails++; $display("FAIL same_cycle_old: got %h expected %h", cpu_rdata, old); end
    model[i] = nv;
    rd(64'(i), d, v);
    checks++; if (d !== {56'h0, nv}) begin fails++; $display("FAIL same_cycle_new: got %h expected %h", d, nv); end
  endtask

  task automatic test_clear(input logic [63:0] ctrl_val);
    int n; logic [63:0] d; logic v;
    fill_pattern(1'b0);
    wr(CTRL, ctrl_val);
    wr(64'd3, 64'hFF);
    rd(CTRL, d, v);
    checks++; if (d !== 64'h1 || v !== 1'b1) begin fails++; $display("FAIL ctrl_status_busy: got %h/%b expected 1/1", d, v); end
    count_busy(n);
    checks++; if (n + 2 !== 36) begin fails++; $display("FAIL clear_len(ctrl=%0h): got %0d expected 36", ctrl_val, n + 2); end
    for (int i = 0; i < CHARS; i++) model[i] = BLANK;
    for (int i = 0; i < CHARS; i++) begin
      rd(64'(i), d, v);
      checks++; if (d !== 64'(model[i])) begin fails++; $display("FAIL clear_data[%0d]: got %h expected %h", i, d, model[i]); end
    end
  endtask

  task automatic test_scroll;
    int n; logic [63:0] d; logic v; logic [7:0] exp_buf [CHARS];
    fill_pattern(1'b0);
    for (int i = 0; i < CHARS; i++) exp_buf[i] = (i < CHARS - COLS) ? model[i + COLS] : BLANK;
    wr(CTRL, 64'h2);
`ifdef VGA_TEXT_SCROLL_EN
    count_busy(n);
    checks++; if (n !== 60) begin fails++; $display("FAIL scroll_len: got %0d expected 60", n); end
    for (int i = 0; i < CHARS; i++) model[i] = exp_buf[i];
`else
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL scroll_ignored_busy: got %b expected 0", busy); end
    count_busy(n);
`endif
    for (int i = 0; i < CHARS; i++) begin
      rd(64'(i), d, v);
      checks++; if (d !== 64'(model[i])) begin fails++; $display("FAIL scroll_data[%0d]: got %h expected %h", i, d, model[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    wr(CTRL, 64'h1);
    count_busy(n);
    checks++; if (n !== 36) begin fails++; $display("FAIL b2b_first_len: got %0d expected 36", n); end
    wr(CTRL, 64'h1);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: got %b expected 1", busy); end
    count_busy(n);
    checks++; if (n !== 36) begin fails++; $display("FAIL b2b_second_len: got %0d expected 36", n); end
  endtask

  task automatic test_unmapped;
    logic [63:0] d; logic v;
    rd(64'h80, d, v);
    checks++; if (d !== 64'h0 || v !== 1'b1) begin fails++; $display("FAIL unmapped_80: got %h/%b expected 0/1", d, v); end
    @(posedge clk); #1;
    checks++; if (cpu_rvalid !== 1'b0) begin fails++; $display("FAIL rvalid_pulse: got %b expected 0", cpu_rvalid); end
    rd(64'(CHARS), d, v);
    checks++; if (d !== 64'h0) begin fails++; $display("FAIL unmapped_chars: got %h expected 0", d); end
    rd(64'hFFFF_FFFF_FFFF_FFFF, d, v);
    checks++; if (d !== 64'h0) begin fails++; $display("FAIL unmapped_below: got %h expected 0", d); end
    rd(CTRL, d, v);
    checks++; if (d !== 64'h0) begin fails++; $display("FAIL ctrl_idle: got %h expected 0", d); end
    fill_pattern(1'b1);
    wr(64'h80, {$urandom, $urandom});
    wr(64'(CHARS), {$urandom, $urandom});
    wr(64'hFFFF_FFFF_FFFF_FFFF, {$urandom, $urandom});
    wr(CTRL + 64'h1, 64'h1);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL unmapped_ctrl_alias: got %b expected 0", busy); end
    for (int i = 0; i < CHARS; i++) begin
      rd(64'(i), d, v);
      checks++; if (d !== 64'(model[i])) begin fails++; $display("FAIL unmapped_keep[%0d]: got %h expected %h", i, d, model[i]); end
    end
  endtask

  task automatic test_reset_mid_fill;
    int n; logic [63:0] d; logic v;
    fill_pattern(1'b1);
`ifdef VGA_TEXT_SCROLL_EN
    wr(CTRL, 64'h2);
`else
    wr(CTRL, 64'h1);
`endif
    repeat (10) @(posedge clk);
    @(negedge clk) aresetn = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || cpu_rvalid !== 1'b0) begin fails++; $display("FAIL midfill_async: got busy=%b rvalid=%b expected 1/0", busy, cpu_rvalid); end
    @(negedge clk) aresetn = 1'b1;
    count_busy(n);
    checks++; if (n !== 36) begin fails++; $display("FAIL midfill_clear_len: got %0d expected 36", n); end
    for (int i = 0; i < CHARS; i++) model[i] = BLANK;
    for (int i = 0; i < CHARS; i++) begin
      rd(64'(i), d, v);
      checks++; if (d !== 64'(BLANK)) begin fails++; $display("FAIL midfill_blank[%0d]: got %h expected %h", i, d, BLANK); end
    end
  endtask

  initial begin
    test_reset;
    test_char_rw;
    test_same_cycle;
    test_clear(64'h1);
    test_scroll;
    test_clear(64'h3);
    test_back_to_back;
    test_unmapped;
    test_reset_mid_fill;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
